// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to the pixel-colour
// generator and the connector driver.
interface vga_timing_if;
    logic       pix_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       line_start;

    modport master (
        output pix_tick, x, y, en, hsync, vsync, frame_start, line_start
    );

    modport slave (
        input pix_tick, x, y, en, hsync, vsync, frame_start, line_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate tick divider, x/y raster counters,
// visible-area enable, line/frame start strobes and hsync/vsync delayed by
// PIPE_DLY pixel periods to line up with the colour path.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,
    parameter bit SYNC_POL  = 1'b0,
    parameter int PIPE_DLY  = 1
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic       ACT      = SYNC_POL;
    localparam logic       IDLE     = ~SYNC_POL;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be in 0..4");
    end

    logic [DW-1:0] div_cnt;
    logic          pix_tick;
    logic [9:0]    x_q, y_q, x_nxt, y_nxt;
    logic          en_q, hs_raw, vs_raw, line_q, frame_q;
    logic          hs_nxt, vs_nxt;
    logic          hsync_out, vsync_out;

    // Pixel-rate divider; the tick is decoded straight from the count so
    // CLK_DIV=1 yields a permanently asserted tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign pix_tick = (div_cnt == DIV_LAST);

    // Next raster position and the qualifiers derived from it, so every
    // registered output is loaded coherently with x/y on the tick edge.
    always_comb begin
        x_nxt = (x_q == X_LAST) ? 10'd0 : x_q + 10'd1;
        y_nxt = y_q;
        if (x_q == X_LAST) begin
            y_nxt = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end
        hs_nxt = (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? ACT : IDLE;
        vs_nxt = (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? ACT : IDLE;
    end

    // Raster counters, enable, raw syncs and one-clk start strobes. Reset
    // parks the counters at the last position so the first tick lands on 0,0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= X_LAST;
            y_q     <= Y_LAST;
            en_q    <= 1'b0;
            hs_raw  <= IDLE;
            vs_raw  <= IDLE;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else if (pix_tick) begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            en_q    <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            hs_raw  <= hs_nxt;
            vs_raw  <= vs_nxt;
            line_q  <= (x_nxt == 10'd0);
            frame_q <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    if (PIPE_DLY == 0) begin : g_no_dly
        assign hsync_out = hs_raw;
        assign vsync_out = vs_raw;
    end else begin : g_dly
        logic [PIPE_DLY-1:0] hs_sr, vs_sr;

        // Sync delay line advancing one stage per pixel period.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hs_sr <= {PIPE_DLY{IDLE}};
                vs_sr <= {PIPE_DLY{IDLE}};
            end else if (pix_tick) begin
                hs_sr[0] <= hs_raw;
                vs_sr[0] <= vs_raw;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    hs_sr[i] <= hs_sr[i-1];
                    vs_sr[i] <= vs_sr[i-1];
                end
            end
        end

        assign hsync_out = hs_sr[PIPE_DLY-1];
        assign vsync_out = vs_sr[PIPE_DLY-1];
    end

    assign vga.pix_tick    = pix_tick;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.en          = en_q;
    assign vga.hsync       = hsync_out;
    assign vga.vsync       = vsync_out;
    assign vga.line_start  = line_q;
    assign vga.frame_start = frame_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the 3x3 cell graphics path: pixel-rate tick, raster coordinates x/y, visible-area enable en, and hsync/vsync.
- x, y and en drive the pixel-colour generator directly.
- hsync/vsync go to the connector, delayed in pixel periods to match the colour path latency.
- Single clock domain. The pixel rate is derived from clk by a tick divider; no second clock.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
CLK_DIV, 4, clk cycles per pixel period; legal range >=1
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
PIPE_DLY, 1, pixel periods of delay applied to hsync/vsync only; legal range 0..4

Ports:
clk  input  1  system clock (100 MHz nominal)
reset  input  1  asynchronous, active-low reset
pix_tick  output  1  high in the clk cycle whose closing edge advances the raster
x  output  10  horizontal counter, 0..H_TOTAL-1
y  output  10  vertical counter, 0..V_TOTAL-1
en  output  1  1 iff x<H_VISIBLE and y<V_VISIBLE
hsync  output  1  horizontal sync, polarity SYNC_POL, delayed PIPE_DLY pixel periods
vsync  output  1  vertical sync, polarity SYNC_POL, delayed PIPE_DLY pixel periods
frame_start  output  1  one-clk pulse when x,y become 0,0
line_start  output  1  one-clk pulse when x becomes 0

Behaviour:
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps; it resets to 0.
  - pix_tick = (div_cnt == CLK_DIV-1), decoded from the register.
  - CLK_DIV=1: pix_tick is constantly 1 after reset.
- Tick edge = rising clk edge with pix_tick=1. All raster state changes only on tick edges.
- Counters are registered; x and y are the counter registers themselves.
  - Reset values: x=H_TOTAL-1 (799), y=V_TOTAL-1 (524).
  - Tick edge with x<H_TOTAL-1: x<=x+1.
  - Tick edge with x=H_TOTAL-1: x<=0, and y<=(y==V_TOTAL-1)?0:y+1.
  - The first tick edge after reset therefore lands on (0,0).
- en is registered and loaded on tick edges from the next x/y values, so it is coherent with x/y in every cycle. Reset value 0.
- Raw sync:
  - hs_raw is active for next x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (default 656..751).
  - vs_raw is active for next y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (default 490..491).
  - vsync is line-based, evaluated on every tick edge; no half-line offset.
- Sync delay:
  - PIPE_DLY=0: hsync/vsync equal the registered raw values.
  - Otherwise: a PIPE_DLY-deep shift register shifts only on tick edges, and its output drives hsync/vsync.
  - All stages reset to the inactive level (~SYNC_POL).
- line_start: set to 1 on a tick edge whose next x=0, cleared on the following clk edge. Exactly one clk cycle wide regardless of CLK_DIV; never longer.
- frame_start: same timing rule as line_start, with next x=0 and next y=0.
- Reset values: pix_tick=0 (CLK_DIV>1) or 1 (CLK_DIV=1), x=799, y=524, en=0, hsync=vsync=~SYNC_POL, frame_start=0, line_start=0.
- Reset asserted mid-operation: all registers return to reset values immediately, without a clock edge. On release the sequence restarts identically to power-up; no partial-line state survives.
- Width rule: all compares are done at 10 bits. H_TOTAL and V_TOTAL must be <=1024 (checked by elaboration assertion).

Test Plan:
1. Default params, release reset: pix_tick first high in the 4th clk cycle. At that tick edge x,y go 799,524 -> 0,0, en=1, frame_start=1 and line_start=1 for exactly 1 clk, then both 0.
2. One line: 800 tick edges between consecutive line_start pulses. en=1 for x=0..639 and 0 for x=640..799. With PIPE_DLY=0, hsync=0 for exactly 96 ticks starting when x=656.
3. One frame: frame_start period = 420000 ticks = 1680000 clk. vsync=0 while y=490..491 (1600 ticks). en=0 for all y>=480.
4. PIPE_DLY=1: hsync falls exactly one pixel period (4 clk) after x becomes 656 and rises one period after x becomes 752. x/y/en timing is unchanged versus PIPE_DLY=0.
5. Assert reset at x=300, y=100 between clk edges: outputs return to reset values with no clk edge. After release, scenario 1 repeats bit-exactly.
6. CLK_DIV=1, SYNC_POL=1: pix_tick constantly 1, x increments every clk, hsync=1 only for x=656..751, and line_start is 1 clk wide.
